// File: rtl/cmp_pipe.sv
// Pipelined compare / overflow-detect unit with 1- or 2-cycle latency,
// stall/flush control and a sticky overflow flag with saturating event counter.
module cmp_pipe #(
   parameter int WIDTH = 32,
   parameter int LAT   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] c1,
   input  logic [WIDTH-1:0] c2,
   input  logic [2:0]       cmp_op,
   input  logic             stall,
   input  logic             flush,
   input  logic             clr_sticky,
   output logic             out_valid,
   output logic             cond,
   output logic             overflow,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);

   localparam logic [2:0] OP_EQ    = 3'd0;
   localparam logic [2:0] OP_NE    = 3'd1;
   localparam logic [2:0] OP_LEZ   = 3'd2;
   localparam logic [2:0] OP_GTZ   = 3'd3;
   localparam logic [2:0] OP_LTZ   = 3'd4;
   localparam logic [2:0] OP_GEZ   = 3'd5;
   localparam logic [2:0] OP_ADDOV = 3'd6;
   localparam logic [2:0] OP_SUBOV = 3'd7;

   // Returns {cond, overflow}; overflow is only ever set by the add/sub modes.
   function automatic logic [1:0] evaluate(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      logic           a_neg;
      logic           a_zero;
      a_neg    = a[WIDTH-1];
      a_zero   = (a == '0);
      s        = '0;
      evaluate = 2'b00;
      case (op)
         OP_EQ:    evaluate = {a == b, 1'b0};
         OP_NE:    evaluate = {a != b, 1'b0};
         OP_LEZ:   evaluate = {a_neg | a_zero, 1'b0};
         OP_GTZ:   evaluate = {~a_neg & ~a_zero, 1'b0};
         OP_LTZ:   evaluate = {a_neg, 1'b0};
         OP_GEZ:   evaluate = {~a_neg, 1'b0};
         OP_ADDOV: begin
            s        = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            evaluate = {2{s[WIDTH] ^ s[WIDTH-1]}};
         end
         OP_SUBOV: begin
            s        = {a[WIDTH-1], a} - {b[WIDTH-1], b};
            evaluate = {2{s[WIDTH] ^ s[WIDTH-1]}};
         end
         default:  evaluate = 2'b00;
      endcase
   endfunction

   // Operation presented to the output stage this cycle.
   logic             adv_valid;
   logic [2:0]       adv_op;
   logic [WIDTH-1:0] adv_c1;
   logic [WIDTH-1:0] adv_c2;

   generate
      if (LAT == 2) begin : g_lat2
         logic             s1_valid;
         logic [2:0]       s1_op;
         logic [WIDTH-1:0] s1_c1;
         logic [WIDTH-1:0] s1_c2;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_valid <= 1'b0;
               s1_op    <= '0;
               s1_c1    <= '0;
               s1_c2    <= '0;
            end else if (flush) begin
               s1_valid <= 1'b0;
            end else if (!stall) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_op <= cmp_op;
                  s1_c1 <= c1;
                  s1_c2 <= c2;
               end
            end
         end

         assign adv_valid = s1_valid;
         assign adv_op    = s1_op;
         assign adv_c1    = s1_c1;
         assign adv_c2    = s1_c2;
      end else begin : g_lat1
         assign adv_valid = in_valid;
         assign adv_op    = cmp_op;
         assign adv_c1    = c1;
         assign adv_c2    = c2;
      end
   endgenerate

   logic [1:0] res;
   logic       load;
   logic       load_ovf;

   assign res      = evaluate(adv_op, adv_c1, adv_c2);
   assign load     = adv_valid & ~stall & ~flush;
   assign load_ovf = load & res[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         cond       <= 1'b0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (!stall) begin
            out_valid <= adv_valid;
            if (adv_valid) begin
               cond     <= res[1];
               overflow <= res[0];
            end
         end
         // A clear coincident with an overflow load leaves exactly that one event counted.
         if (clr_sticky) begin
            ovf_sticky <= load_ovf;
            ovf_count  <= load_ovf ? CNT_W'(1) : '0;
         end else if (load_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != '1) begin
               ovf_count <= ovf_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal 8..64).
REQ-002 SHALL have parameter LAT, default 1, meaning accept-to-result latency in cycles (legal 1 or 2).
REQ-003 SHALL have parameter CNT_W, default 8, meaning overflow event counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operands and op on this cycle are offered.
REQ-007 SHALL have port c1  input  WIDTH  first operand, two's complement.
REQ-008 SHALL have port c2  input  WIDTH  second operand, two's complement.
REQ-009 SHALL have port cmp_op  input  3  compare mode (REQ-016).
REQ-010 SHALL have port stall  input  1  freeze all pipeline state.
REQ-011 SHALL have port flush  input  1  discard all in-flight and offered operations.
REQ-012 SHALL have port clr_sticky  input  1  clear sticky flag and counter.
REQ-013 SHALL have port out_valid  output  1  cond/overflow are valid results.
REQ-014 SHALL have ports cond  output  1, overflow  output  1, ovf_sticky  output  1, ovf_count  output  CNT_W, all registered.

Function
REQ-015 SHALL accept an operation when in_valid=1, stall=0 and flush=0; otherwise the offer is dropped (no internal queue).
REQ-016 SHALL compute per cmp_op: 0 EQ c1==c2; 1 NE c1!=c2; 2 LEZ c1<=0; 3 GTZ c1>0; 4 LTZ c1<0; 5 GEZ c1>=0; 6 ADDOV; 7 SUBOV; modes 2-5 signed, ignore c2.
REQ-017 SHALL, for ADDOV/SUBOV, sign-extend both operands to WIDTH+1 bits, form c1+c2 / c1-c2, set overflow = (bit WIDTH != bit WIDTH-1) and cond = overflow.
REQ-018 SHALL drive overflow=0 for modes 0-5.
REQ-019 SHALL, with LAT=1, register the result so it appears with out_valid=1 on the cycle after acceptance.
REQ-020 SHALL, with LAT=2, register operands/op in stage 1 and the result in stage 2, result appearing two cycles after acceptance; sustained throughput one op per cycle.
REQ-021 SHALL, while stall=1 and flush=0, hold every pipeline register, out_valid, cond and overflow unchanged.
REQ-022 SHALL, on flush=1, clear all stage valids (out_valid=0 next cycle) regardless of stall; flush has priority over stall and in_valid.
REQ-023 SHALL drive out_valid=0 on any cycle following a non-stalled cycle in which no result advanced into the output register; cond and overflow hold last value when out_valid=0.
REQ-024 SHALL set ovf_sticky and increment ovf_count when a result with overflow=1 is loaded into the output register.
REQ-025 SHALL saturate ovf_count at 2^CNT_W-1 (no wrap).
REQ-026 SHALL, on clr_sticky=1, clear ovf_sticky and ovf_count; if an overflow result loads the same cycle, end state is ovf_sticky=1, ovf_count=1.
REQ-027 SHALL not update sticky/count on stalled or flushed cycles.

Reset
REQ-028 SHALL, while reset=1, immediately force out_valid=0, cond=0, overflow=0, ovf_sticky=0, ovf_count=0 and all stage valids to 0, independent of clk.
REQ-029 SHALL, on reset mid-operation, discard all in-flight operations; first accept after reset release behaves as from idle.

Verification
REQ-030 SHALL cover: LAT=1, WIDTH=32, EQ c1=c2=0x1234 accepted at cycle N -> out_valid=1, cond=1, overflow=0 at N+1; then in_valid=0 -> out_valid=0 at N+2.
REQ-031 SHALL cover: ADDOV c1=0x7FFFFFFF, c2=0x00000001 -> cond=1, overflow=1, ovf_sticky=1, ovf_count=1; SUBOV c1=0x80000000, c2=1 -> overflow=1, ovf_count=2; ADDOV 0xFFFFFFFF+0x00000001 -> overflow=0.
REQ-032 SHALL cover: LAT=2 back-to-back LTZ c1=0x80000000 then GEZ c1=0 then LEZ c1=1 -> results 1,1,0 on consecutive cycles N+2..N+4; stall=1 for 2 cycles mid-stream -> outputs frozen, no result lost or duplicated.
REQ-033 SHALL cover: LAT=2 two ops in flight, flush=1 with stall=1 -> out_valid=0 next cycle, neither op ever emitted, ovf_count unchanged.
REQ-034 SHALL cover: CNT_W=2, five overflowing ADDOV results -> ovf_count stops at 3; clr_sticky=1 coincident with a sixth overflowing result -> ovf_sticky=1, ovf_count=1.
REQ-035 SHALL cover: reset=1 asserted asynchronously between clk edges with out_valid=1, ovf_count=3 -> all outputs 0 before the next edge; WIDTH=8 ADDOV 0x7F+0x01 after release -> overflow=1.
